// File: rtl/spi_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_loader_pkg
// Description : Shared opcodes and FSM state encoding for the SPI word loader.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_loader_pkg;

    localparam logic [7:0] OP_ADDR = 8'h01;
    localparam logic [7:0] OP_DATA = 8'h02;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR_OP   = 3'd1,
        ADDR_BYTE = 3'd2,
        DATA_OP   = 3'd3,
        DATA_BYTE = 3'd4,
        NEXT      = 3'd5
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_loader_fifo
// Description : Synchronous word FIFO with full/empty flags; a push and a pop
//               in the same cycle both take effect.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : spi_word_loader
// Description : Streams buffered words to an SPI master as an address frame
//               (0x01 + address) and a data frame (0x02 + data), MSB first.
//               Define SPI_WORD_LOADER_BURST_EN to send the address frame only
//               for the first word after reset or an accepted address load.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_word_loader
    import spi_loader_pkg::*;
#(
    parameter int ADDR_BYTES = 4,
    parameter int DATA_BYTES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    addr_load,
    input  logic [8*ADDR_BYTES-1:0] addr_in,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    spi_start,
    output logic [7:0]              spi_data,
    input  logic                    spi_done,
    output logic                    busy,
    output logic                    addr_err,
    output logic [15:0]             word_count
);

    localparam int              c_aw        = 8 * ADDR_BYTES;
    localparam int              c_dw        = 8 * DATA_BYTES;
    localparam logic [2:0]      c_addr_last = 3'(ADDR_BYTES - 1);
    localparam logic [2:0]      c_data_last = 3'(DATA_BYTES - 1);
    localparam logic [c_aw-1:0] c_addr_step = c_aw'(DATA_BYTES);

    loader_state_t   r_state;
    loader_state_t   w_next_state;
    logic            r_wait;
    logic [2:0]      r_cnt;
    logic            r_spi_start;
    logic [7:0]      r_spi_data;
    logic            r_addr_err;
    logic [15:0]     r_word_count;
    logic [c_aw-1:0] r_addr;
    logic [c_aw-1:0] r_addr_sh;
    logic [c_dw-1:0] r_data_sh;

    logic            w_issue;
    logic [7:0]      w_issue_byte;
    logic            w_pop;
    logic            w_retire;
    logic            w_done_ok;
    logic            w_push;
    logic            w_addr_accept;
    logic            w_use_addr_frame;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [c_dw-1:0] w_fifo_rdata;

    spi_loader_fifo #(
        .WIDTH (c_dw),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (wr_data),
        .o_full  (w_fifo_full),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty)
    );

    assign wr_ready      = !w_fifo_full;
    assign w_push        = wr_valid && wr_ready;
    assign busy          = (r_state != IDLE) || !w_fifo_empty;
    assign w_addr_accept = addr_load && !busy;
    // A done pulse only counts while a byte is outstanding.
    assign w_done_ok     = r_wait && spi_done;

`ifdef SPI_WORD_LOADER_BURST_EN
    logic r_addr_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_pending <= 1'b1;
        end else if (w_addr_accept) begin
            r_addr_pending <= 1'b1;
        end else if (w_pop) begin
            r_addr_pending <= 1'b0;
        end
    end

    assign w_use_addr_frame = r_addr_pending;
`else
    assign w_use_addr_frame = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_issue_byte = 8'h00;
        w_pop        = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                // The word leaves the FIFO as its opcode goes out, freeing a slot.
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_byte = w_use_addr_frame ? OP_ADDR : OP_DATA;
                    w_next_state = w_use_addr_frame ? ADDR_OP : DATA_OP;
                end
            end
            ADDR_OP: begin
                if (!r_wait) begin
                    w_issue      = 1'b1;
                    w_issue_byte = OP_ADDR;
                end else if (spi_done) begin
                    w_next_state = ADDR_BYTE;
                end
            end
            ADDR_BYTE: begin
                if (!r_wait) begin
                    w_issue      = 1'b1;
                    w_issue_byte = r_addr_sh[c_aw-1 -: 8];
                end else if (spi_done && (r_cnt == c_addr_last)) begin
                    w_next_state = DATA_OP;
                end
            end
            DATA_OP: begin
                if (!r_wait) begin
                    w_issue      = 1'b1;
                    w_issue_byte = OP_DATA;
                end else if (spi_done) begin
                    w_next_state = DATA_BYTE;
                end
            end
            DATA_BYTE: begin
                if (!r_wait) begin
                    w_issue      = 1'b1;
                    w_issue_byte = r_data_sh[c_dw-1 -: 8];
                end else if (spi_done && (r_cnt == c_data_last)) begin
                    w_next_state = NEXT;
                end
            end
            NEXT: begin
                w_retire     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait       <= 1'b0;
            r_cnt        <= 3'd0;
            r_spi_start  <= 1'b0;
            r_spi_data   <= 8'h00;
            r_addr_err   <= 1'b0;
            r_word_count <= 16'd0;
            r_addr       <= '0;
            r_addr_sh    <= '0;
            r_data_sh    <= '0;
        end else begin
            r_spi_start <= w_issue;
            r_addr_err  <= addr_load && busy;

            if (w_issue) begin
                r_spi_data <= w_issue_byte;
                r_wait     <= 1'b1;
            end else if (w_done_ok) begin
                r_wait     <= 1'b0;
            end

            if (w_done_ok) begin
                if (((r_state == ADDR_BYTE) && (r_cnt != c_addr_last)) ||
                    ((r_state == DATA_BYTE) && (r_cnt != c_data_last))) begin
                    r_cnt <= r_cnt + 3'd1;
                end else begin
                    r_cnt <= 3'd0;
                end
            end

            if (w_pop) begin
                r_addr_sh <= r_addr;
                r_data_sh <= w_fifo_rdata;
            end else if (w_done_ok && (r_state == ADDR_BYTE)) begin
                r_addr_sh <= r_addr_sh << 8;
            end else if (w_done_ok && (r_state == DATA_BYTE)) begin
                r_data_sh <= r_data_sh << 8;
            end

            if (w_addr_accept) begin
                r_addr <= addr_in;
            end else if (w_retire) begin
                r_addr <= r_addr + c_addr_step;
            end

            if (w_retire) begin
                r_word_count <= r_word_count + 16'd1;
            end
        end
    end

    assign spi_start  = r_spi_start;
    assign spi_data   = r_spi_data;
    assign addr_err   = r_addr_err;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_spi_word_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_word_loader
// Description : Scoreboard bench for spi_word_loader with an SPI byte responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_word_loader;

`ifdef SPI_WORD_LOADER_BURST_EN
    localparam bit c_burst = 1'b1;
`else
    localparam bit c_burst = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_done;
    logic        busy;
    logic        addr_err;
    logic [15:0] word_count;

    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [8:0]  exp_q[$];
    logic [31:0] m_addr;
    int          m_wc;
    bit          m_pend;
    int          last_hdr;
    int          byte_cnt  = 0;
    int          hold_at   = -1;
    bit          skip_done = 1'b0;
    bit          stray_req = 1'b0;

    spi_word_loader dut (
        .clk        (clk),
        .reset      (reset),
        .addr_load  (addr_load),
        .addr_in    (addr_in),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .spi_start  (spi_start),
        .spi_data   (spi_data),
        .spi_done   (spi_done),
        .busy       (busy),
        .addr_err   (addr_err),
        .word_count (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue the full byte stream a word should produce.
    task automatic expect_word(input logic [31:0] data);
        last_hdr = 0;
        if (!c_burst || m_pend) begin
            exp_q.push_back(9'h001);
            for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, m_addr[8*i +: 8]});
            last_hdr = 5;
        end
        m_pend = 1'b0;
        exp_q.push_back(9'h002);
        for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, data[8*i +: 8]});
        m_addr = m_addr + 32'd4;
        m_wc++;
    endtask

    task automatic load_addr(input logic [31:0] a, input bit accept);
        @(posedge clk); #1;
        addr_load = 1'b1;
        addr_in   = a;
        @(posedge clk); #1;
        addr_load = 1'b0;
        if (accept) begin
            m_addr = a;
            m_pend = 1'b1;
        end
        check("addr_err_pulse", 32'(addr_err), 32'(!accept));
        @(posedge clk); #1;
        check("addr_err_width", 32'(addr_err), 32'd0);
    endtask

    task automatic push_words(input int n, input logic [31:0] d0);
        int t;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = d0 ^ (32'h1111_1111 * 32'(i));
            t = 0;
            while (!wr_ready && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
            else         expect_word(wr_data);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            check("idle_timeout_busy", 32'(busy), 32'd0);
            check("idle_timeout_bytes", 32'(exp_q.size()), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_bytes(input int target);
        int n = 0;
        while (byte_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("byte_wait_timeout", 32'(byte_cnt), 32'(target));
    endtask

    // SPI master stand-in: scores each byte, then answers with spi_done.
    initial begin : responder
        logic [7:0] held;
        logic [8:0] exp_b;
        spi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                byte_cnt++;
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
                check("spi_byte", {24'd0, spi_data}, {23'd0, exp_b});
                held = spi_data;
                while (hold_at == byte_cnt) @(negedge clk);
                if (skip_done) begin
                    skip_done = 1'b0;
                end else begin
                    repeat (2) begin
                        @(negedge clk);
                        check("data_held", {24'd0, spi_data}, {24'd0, held});
                        check("no_early_start", 32'(spi_start), 32'd0);
                    end
                    @(posedge clk); #1 spi_done = 1'b1;
                    @(posedge clk); #1 spi_done = 1'b0;
                end
            end else if (stray_req) begin
                @(posedge clk); #1 spi_done = 1'b1;
                @(posedge clk); #1 spi_done = 1'b0;
                stray_req = 1'b0;
            end
        end
    end

    initial begin : main
        int n;
        int base;
        int accepted;
        reset     = 1'b1;
        addr_load = 1'b0;
        addr_in   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        m_addr    = '0;
        m_wc      = 0;
        m_pend    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_spi_data", {24'd0, spi_data}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_word_count", {16'd0, word_count}, 32'd0);

        // Single word, also measures push-to-first-start latency.
        load_addr(32'h1000_0000, 1'b1);
        push_words(1, 32'hDEAD_BEEF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (spi_start !== 1'b1 && n < 10);
        check("first_start_latency", 32'(n), 32'd2);
        wait_idle(300);
        check("wc_single", {16'd0, word_count}, 32'(m_wc));

        // Back-to-back words, address steps by 4.
        load_addr(32'h1000_0000, 1'b1);
        push_words(3, 32'hA0B1_C2D3);
        wait_idle(1000);
        check("wc_three", {16'd0, word_count}, 32'(m_wc));

        // Address wrap.
        load_addr(32'hFFFF_FFFC, 1'b1);
        push_words(2, 32'h1234_5678);
        wait_idle(800);
        check("wc_wrap", {16'd0, word_count}, 32'(m_wc));

        // Backpressure with spi_done withheld on the first byte.
        hold_at  = byte_cnt + 1;
        accepted = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            if (!wr_ready) break;
            wr_valid = 1'b1;
            wr_data  = 32'hC000_0000 + 32'(i);
            expect_word(wr_data);
            @(posedge clk); #1;
            accepted++;
        end
        wr_valid = 1'b0;
        check("accepted_words", 32'(accepted), 32'd5);
        check("wr_ready_full", 32'(wr_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("wr_ready_stays_low", 32'(wr_ready), 32'd0);
        hold_at = -1;
        wait_idle(2000);
        check("wc_backpressure", {16'd0, word_count}, 32'(m_wc));

        // Address load while sending data bytes is rejected.
        base = byte_cnt;
        push_words(1, 32'h0BAD_F00D);
        wait_bytes(base + last_hdr + 2);
        load_addr(32'h5555_0000, 1'b0);
        wait_idle(400);
        push_words(1, 32'h600D_CAFE);
        wait_idle(400);
        check("wc_rejected_load", {16'd0, word_count}, 32'(m_wc));

        // Stray spi_done while idle is ignored.
        stray_req = 1'b1;
        n = 0;
        while (stray_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_wc", {16'd0, word_count}, 32'(m_wc));

        // Address load in the same cycle as a push into an empty FIFO.
        @(posedge clk); #1;
        addr_load = 1'b1;
        addr_in   = 32'h2000_0000;
        wr_valid  = 1'b1;
        wr_data   = 32'h1357_9BDF;
        m_addr    = 32'h2000_0000;
        m_pend    = 1'b1;
        expect_word(wr_data);
        @(posedge clk); #1;
        addr_load = 1'b0;
        wr_valid  = 1'b0;
        check("load_with_push_err", 32'(addr_err), 32'd0);
        wait_idle(400);
        check("wc_load_with_push", {16'd0, word_count}, 32'(m_wc));

        // Reset while the address bytes are in flight.
        load_addr(32'h3000_0000, 1'b1);
        base    = byte_cnt;
        hold_at = base + 2;
        push_words(1, 32'hFACE_0001);
        wait_bytes(base + 2);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("midrst_spi_start", 32'(spi_start), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        exp_q.delete();
        m_addr    = '0;
        m_wc      = 0;
        m_pend    = 1'b1;
        skip_done = 1'b1;
        hold_at   = -1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_start", 32'(spi_start), 32'd0);
        end
        check("post_rst_wc", {16'd0, word_count}, 32'd0);
        push_words(1, 32'h0000_00A5);
        wait_idle(400);
        check("wc_after_reset", {16'd0, word_count}, 32'(m_wc));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
